mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage between the execute stage and the write-back stage of the five-stage LoongArch pipeline. Accepts instructions from EXE after their data-SRAM address handshake, waits for the matching `data_sram_data_ok` response, extracts and extends load data, and hands the final result to WB. Tracks responses owed to flushed instructions so that late `data_ok` beats are discarded in order. Also drives forwarding, stall and exception-kill information back to ID and EXE.

## Interface
- `RESULT_W`, 32, width of pc, result and load data.
- `clk`  in  1  clock; all state updates on rising edge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `es_to_ms_valid`  in  1  EXE presents an instruction.
- `ms_allowin`  out  1  MEM can accept an instruction this cycle.
- `es_pc`  in  32  instruction pc.
- `es_result`  in  32  ALU/mul/div/counter result.
- `es_dest`  in  5  destination GR.
- `es_gr_we`  in  1  GR write enable.
- `es_res_from_mem`  in  1  result comes from a load.
- `es_ld_op`  in  5  {ld_b, ld_bu, ld_h, ld_hu, ld_w}.
- `es_addr_lo`  in  2  low two bits of the access address.
- `es_mem_req`  in  1  EXE had a load/store request accepted (`addr_ok`) for this instruction.
- `es_ex`  in  1  instruction already carries an exception.
- `data_sram_data_ok`  in  1  response beat for the oldest outstanding request.
- `data_sram_rdata`  in  32  response data.
- `wb_flush`  in  1  WB exception, ertn or refetch; kills MEM.
- `ws_allowin`  in  1  WB can accept.
- `ms_to_ws_valid`  out  1  result valid for WB.
- `ms_pc`  out  32  registered pc.
- `ms_final_result`  out  32  load data or `es_result`.
- `ms_dest`  out  5  destination GR.
- `ms_gr_we`  out  1  GR write enable; 0 when `ms_ex`.
- `ms_ex`  out  1  registered exception flag; gated with valid.
- `ms_ex_kill`  out  1  `ms_valid & ms_ex`; EXE clears store strobes.
- `ms_fwd_valid`  out  1  `ms_valid & ms_gr_we & dest!=0`.
- `ms_fwd_dest`  out  5  forwarding destination.
- `ms_fwd_data`  out  32  forwarding data.
- `ms_fwd_stall`  out  1  load in MEM whose data is not yet forwardable.

## Operation
- States: `EMPTY` (`ms_valid`=0), `WAIT` (valid, `mem_req`, data not held), `READY` (valid; no request, or data latched in `rdata_r`).
- Accept when `es_to_ms_valid & ms_allowin & !wb_flush`. Next state is `WAIT` if `es_mem_req`, else `READY`.
- `discard_cnt` (2 bits) counts responses owed to killed instructions. While `discard_cnt`≠0, each `data_ok` decrements it and is ignored.
- `WAIT` plus a `data_ok` with `discard_cnt`=0: latch `rdata` into `rdata_r` and go to `READY`. The data is also usable in the same cycle.
- `ms_ready_go` = `!mem_req | data_got | (data_ok & discard_cnt==0)`.
- `ms_allowin` = `!ms_valid | (ms_ready_go & ws_allowin)`.
- Load extraction uses `es_addr_lo`:
  - ld_b/ld_bu select byte `rdata[8*lo+7:8*lo]`, sign- or zero-extended.
  - ld_h/ld_hu select half `rdata[16*lo[1]+15:16*lo[1]]`.
  - ld_w passes all 32 bits.
- Stores: `mem_req`=1 with `res_from_mem`=0. MEM waits for `data_ok` and discards the data.
- `wb_flush` behaviour:
  - `ms_valid` goes to 0.
  - `discard_cnt` += 1 if MEM was in `WAIT` and no unclaimed `data_ok` arrives this cycle.
  - `discard_cnt` += 1 if an EXE instruction with `es_mem_req` transfers this cycle.
  - The result must be net-correct when an increment and a decrement happen in the same cycle.
- `discard_cnt` never exceeds 2. Reaching 3 is a design error; assert it in simulation.

## Timing
- Reset values: `ms_valid`=0, state `EMPTY`, `discard_cnt`=0, `rdata_r`=0. Every output is 0 except `ms_allowin`=1.
- Non-memory instruction: accepted in cycle N, `ms_to_ws_valid` in N+1.
- Load: `ms_to_ws_valid` is asserted combinationally in the `data_ok` cycle. Minimum latency is N+1 when `data_ok` arrives in N+1.
- When WB stalls, data stays in `rdata_r` and all outputs are held stable.
- `ms_fwd_stall` = `ms_valid & res_from_mem & !ms_ex & state==WAIT`, subject to `MS_LOAD_FWD_EN`.
- `resetn` deasserted mid-transaction clears everything immediately. No discard tracking survives reset; the SRAM side is reset together with MEM.

## Configuration
- `MS_LOAD_FWD_EN` defined:
  - `ms_fwd_stall` drops in the `data_ok` cycle.
  - `ms_fwd_data` carries the extracted live `rdata` in that cycle.
- `MS_LOAD_FWD_EN` undefined:
  - `ms_fwd_stall` stays high through the `data_ok` cycle.
  - Forwarding uses `rdata_r` only, from the following cycle.
  - `ms_to_ws_valid` timing is unchanged.

## Test plan
- ALU op, result 0x1234_5678, dest 5, `ws_allowin`=1 → `ms_to_ws_valid` next cycle, `ms_final_result`=0x1234_5678, `ms_fwd_valid`=1.
- ld_b, `addr_lo`=3, `data_ok` 2 cycles later with rdata 0x80FF_0000 → `final_result`=0xFFFF_FF80; ld_bu → 0x0000_0080; ld_hu, lo=2 → 0x0000_80FF.
- Load in `WAIT`, `wb_flush`, `data_ok` two cycles later, then a new ld_w gets `data_ok` rdata 0xCAFE_F00D → first beat discarded, result 0xCAFE_F00D.
- Load data arrives while `ws_allowin`=0 for 3 cycles → `ms_allowin`=0 throughout, result held; transfer when `ws_allowin` rises.
- Flush in the same cycle MEM is waiting and a new request transfers (`data_ok` that cycle unclaimed is absent) → `discard_cnt`=2; the next two `data_ok` beats are ignored.
- `es_ex`=1 instruction → `ms_gr_we`=0, `ms_ex_kill`=1, `ms_to_ws_valid` next cycle, no `data_ok` wait.

Source files
------------

// File: rtl/mem_stage_if.sv
// mem_stage_if: EXE-to-MEM handshake and instruction payload bundle.
//   master (EXE): drives es_to_ms_valid and the es_* payload, samples ms_allowin.
//   slave  (MEM): samples es_to_ms_valid and the es_* payload, drives ms_allowin.
//   Payload: pc, result, dest, gr_we, res_from_mem, ld_op {ld_b,ld_bu,ld_h,ld_hu,ld_w},
//            addr_lo, mem_req (addr_ok already seen), ex (exception already raised).
interface mem_stage_if #(parameter int RESULT_W = 32) ();
    logic                es_to_ms_valid;
    logic                ms_allowin;
    logic [RESULT_W-1:0] es_pc;
    logic [RESULT_W-1:0] es_result;
    logic [4:0]          es_dest;
    logic                es_gr_we;
    logic                es_res_from_mem;
    logic [4:0]          es_ld_op;
    logic [1:0]          es_addr_lo;
    logic                es_mem_req;
    logic                es_ex;
    modport master (
        output es_to_ms_valid, es_pc, es_result, es_dest, es_gr_we, es_res_from_mem,
               es_ld_op, es_addr_lo, es_mem_req, es_ex,
        input  ms_allowin
    );
    modport slave (
        input  es_to_ms_valid, es_pc, es_result, es_dest, es_gr_we, es_res_from_mem,
               es_ld_op, es_addr_lo, es_mem_req, es_ex,
        output ms_allowin
    );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: LoongArch MEM stage; waits for data_sram_data_ok, extends load data,
//   hands results to WB and discards response beats owed to flushed instructions.
//   Ports: clk, resetn (async, active-low); es (mem_stage_if.slave) from EXE;
//   data_sram_data_ok/data_sram_rdata response; wb_flush, ws_allowin from WB;
//   ms_to_ws_valid, ms_pc, ms_final_result, ms_dest, ms_gr_we, ms_ex to WB;
//   ms_ex_kill to EXE; ms_fwd_valid/dest/data/stall to ID.
//   Option: MS_LOAD_FWD_EN forwards live response data in the data_ok cycle.
module mem_stage #(parameter int RESULT_W = 32) (
    input  logic                clk,
    input  logic                resetn,
    mem_stage_if.slave          es,
    input  logic                data_sram_data_ok,
    input  logic [RESULT_W-1:0] data_sram_rdata,
    input  logic                wb_flush,
    input  logic                ws_allowin,
    output logic                ms_to_ws_valid,
    output logic [RESULT_W-1:0] ms_pc,
    output logic [RESULT_W-1:0] ms_final_result,
    output logic [4:0]          ms_dest,
    output logic                ms_gr_we,
    output logic                ms_ex,
    output logic                ms_ex_kill,
    output logic                ms_fwd_valid,
    output logic [4:0]          ms_fwd_dest,
    output logic [RESULT_W-1:0] ms_fwd_data,
    output logic                ms_fwd_stall
);
    typedef enum logic [1:0] {S_EMPTY, S_WAIT, S_READY} state_t;
    state_t              state_q, state_d;
    logic [RESULT_W-1:0] pc_q, pc_d, result_q, result_d, rdata_q, rdata_d;
    logic [4:0]          dest_q, dest_d, ld_op_q, ld_op_d;
    logic [1:0]          addr_lo_q, addr_lo_d, discard_cnt_q, discard_cnt_d;
    logic                gr_we_q, gr_we_d, res_from_mem_q, res_from_mem_d, ex_q, ex_d;
    logic [2:0]          discard_sum;
    logic                ms_valid, data_claim, ms_ready_go, accept;
    logic [RESULT_W-1:0] load_data;

    function automatic logic [RESULT_W-1:0] extract(input logic [RESULT_W-1:0] d,
                                                    input logic [4:0] op, input logic [1:0] lo);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[{lo, 3'b000} +: 8];
        h = lo[1] ? d[31:16] : d[15:0];
        return op[4] ? {{(RESULT_W-8){b[7]}}, b}   : op[3] ? {{(RESULT_W-8){1'b0}}, b} :
               op[2] ? {{(RESULT_W-16){h[15]}}, h} : op[1] ? {{(RESULT_W-16){1'b0}}, h} : d;
    endfunction

    assign ms_valid      = state_q != S_EMPTY;
    // A beat belongs to the waiting instruction only once every owed discard is drained.
    assign data_claim    = (state_q == S_WAIT) & data_sram_data_ok & (discard_cnt_q == 2'd0);
    assign ms_ready_go   = (state_q == S_READY) | data_claim;
    assign es.ms_allowin = !ms_valid | (ms_ready_go & ws_allowin);
    assign accept        = es.es_to_ms_valid & es.ms_allowin & !wb_flush;
    assign load_data     = extract(state_q == S_WAIT ? data_sram_rdata : rdata_q, ld_op_q, addr_lo_q);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= S_EMPTY;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = wb_flush                   ? S_EMPTY :
                  accept                     ? (es.es_mem_req ? S_WAIT : S_READY) :
                  (ms_ready_go & ws_allowin) ? S_EMPTY :
                  data_claim                 ? S_READY : state_q;
    end

    always_comb begin
        pc_d           = accept ? es.es_pc           : pc_q;
        result_d       = accept ? es.es_result       : result_q;
        dest_d         = accept ? es.es_dest         : dest_q;
        gr_we_d        = accept ? es.es_gr_we        : gr_we_q;
        res_from_mem_d = accept ? es.es_res_from_mem : res_from_mem_q;
        ld_op_d        = accept ? es.es_ld_op        : ld_op_q;
        addr_lo_d      = accept ? es.es_addr_lo      : addr_lo_q;
        ex_d           = accept ? es.es_ex           : ex_q;
        rdata_d        = data_claim ? data_sram_rdata : rdata_q;
        // Owed beats: the killed waiting load (unless its beat lands now) and EXE's
        // accepted request, which dies with the flush whether or not MEM could take it.
        discard_sum    = {1'b0, discard_cnt_q}
                       + {2'b0, wb_flush & (state_q == S_WAIT) & !data_claim}
                       + {2'b0, wb_flush & es.es_to_ms_valid & es.es_mem_req}
                       - {2'b0, data_sram_data_ok & (discard_cnt_q != 2'd0)};
        discard_cnt_d  = discard_sum[1:0];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_q           <= '0;
            result_q       <= '0;
            dest_q         <= '0;
            gr_we_q        <= 1'b0;
            res_from_mem_q <= 1'b0;
            ld_op_q        <= '0;
            addr_lo_q      <= '0;
            ex_q           <= 1'b0;
            rdata_q        <= '0;
            discard_cnt_q  <= '0;
        end else begin
            pc_q           <= pc_d;
            result_q       <= result_d;
            dest_q         <= dest_d;
            gr_we_q        <= gr_we_d;
            res_from_mem_q <= res_from_mem_d;
            ld_op_q        <= ld_op_d;
            addr_lo_q      <= addr_lo_d;
            ex_q           <= ex_d;
            rdata_q        <= rdata_d;
            discard_cnt_q  <= discard_cnt_d;
        end
    end

    always_comb begin
        ms_to_ws_valid  = ms_valid & ms_ready_go;
        ms_pc           = pc_q;
        ms_final_result = res_from_mem_q ? load_data : result_q;
        ms_dest         = dest_q;
        ms_gr_we        = gr_we_q & !ex_q;
        ms_ex           = ms_valid & ex_q;
        ms_ex_kill      = ms_ex;
        ms_fwd_valid    = ms_valid & ms_gr_we & (dest_q != 5'd0);
        ms_fwd_dest     = dest_q;
`ifdef MS_LOAD_FWD_EN
        ms_fwd_data     = ms_final_result;
        ms_fwd_stall    = ms_valid & res_from_mem_q & !ex_q & (state_q == S_WAIT) & !data_claim;
`else
        ms_fwd_data     = res_from_mem_q ? extract(rdata_q, ld_op_q, addr_lo_q) : result_q;
        ms_fwd_stall    = ms_valid & res_from_mem_q & !ex_q & (state_q == S_WAIT);
`endif
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (resetn) assert (discard_sum < 3'd3);
    end
`endif
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vectors for mem_stage with hand-computed expectations.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        data_ok = 1'b0, wb_flush = 1'b0, ws_allowin = 1'b1;
    logic [31:0] rdata = '0;
    logic        ms_to_ws_valid, ms_gr_we, ms_ex, ms_ex_kill, ms_fwd_valid, ms_fwd_stall;
    logic [31:0] ms_pc, ms_final_result, ms_fwd_data;
    logic [4:0]  ms_dest, ms_fwd_dest;
    int          n_vec = 0, n_err = 0;
`ifdef MS_LOAD_FWD_EN
    localparam logic STALL_ON_OK = 1'b0;
`else
    localparam logic STALL_ON_OK = 1'b1;
`endif

    mem_stage_if #(.RESULT_W(32)) es_if ();

    mem_stage #(.RESULT_W(32)) dut (
        .clk(clk), .resetn(resetn), .es(es_if),
        .data_sram_data_ok(data_ok), .data_sram_rdata(rdata),
        .wb_flush(wb_flush), .ws_allowin(ws_allowin),
        .ms_to_ws_valid(ms_to_ws_valid), .ms_pc(ms_pc), .ms_final_result(ms_final_result),
        .ms_dest(ms_dest), .ms_gr_we(ms_gr_we), .ms_ex(ms_ex), .ms_ex_kill(ms_ex_kill),
        .ms_fwd_valid(ms_fwd_valid), .ms_fwd_dest(ms_fwd_dest), .ms_fwd_data(ms_fwd_data),
        .ms_fwd_stall(ms_fwd_stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        es_if.es_to_ms_valid  = 1'b0;
        es_if.es_pc           = '0;
        es_if.es_result       = '0;
        es_if.es_dest         = '0;
        es_if.es_gr_we        = 1'b0;
        es_if.es_res_from_mem = 1'b0;
        es_if.es_ld_op        = '0;
        es_if.es_addr_lo      = '0;
        es_if.es_mem_req      = 1'b0;
        es_if.es_ex           = 1'b0;
    endtask

    task automatic send(input logic [31:0] pc, input logic [31:0] res, input logic [4:0] dest,
                        input logic [4:0] op, input logic [1:0] lo, input logic we,
                        input logic rfm, input logic req, input logic ex);
        es_if.es_to_ms_valid  = 1'b1;
        es_if.es_pc           = pc;
        es_if.es_result       = res;
        es_if.es_dest         = dest;
        es_if.es_gr_we        = we;
        es_if.es_res_from_mem = rfm;
        es_if.es_ld_op        = op;
        es_if.es_addr_lo      = lo;
        es_if.es_mem_req      = req;
        es_if.es_ex           = ex;
    endtask

    // Load accepted in cycle N, response in N+2.
    task automatic load_case(input string tag, input logic [4:0] op, input logic [1:0] lo,
                             input logic [31:0] d, input logic [31:0] exp);
        tick; send(32'h1c00_0100, 32'h0, 5'd7, op, lo, 1'b1, 1'b1, 1'b1, 1'b0);
        tick; idle; #1;
        check({tag, "_wait_valid"}, ms_to_ws_valid, 0);
        check({tag, "_wait_stall"}, ms_fwd_stall, 1);
        tick; data_ok = 1'b1; rdata = d; #1;
        check({tag, "_valid"}, ms_to_ws_valid, 1);
        check({tag, "_result"}, ms_final_result, exp);
        check({tag, "_ok_stall"}, ms_fwd_stall, STALL_ON_OK);
        tick; data_ok = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        idle;
        #1 resetn = 1'b0;
        #1;
        check("rst_allowin", es_if.ms_allowin, 1);
        check("rst_to_ws", ms_to_ws_valid, 0);
        check("rst_pc", ms_pc, 0);
        check("rst_result", ms_final_result, 0);
        check("rst_fwd", {ms_fwd_valid, ms_fwd_stall, ms_ex_kill, ms_gr_we, ms_ex}, 0);
        check("rst_fwd_data", ms_fwd_data, 0);
        #11 resetn = 1'b1;

        tick; send(32'h1c00_0000, 32'h1234_5678, 5'd5, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0); #1;
        check("alu_allowin", es_if.ms_allowin, 1);
        tick; idle; #1;
        check("alu_valid", ms_to_ws_valid, 1);
        check("alu_result", ms_final_result, 32'h1234_5678);
        check("alu_pc", ms_pc, 32'h1c00_0000);
        check("alu_fwd_valid", ms_fwd_valid, 1);
        check("alu_fwd_dest", ms_fwd_dest, 5);
        check("alu_fwd_data", ms_fwd_data, 32'h1234_5678);
        tick; #1;
        check("alu_drained", ms_to_ws_valid, 0);

        load_case("ld_b3",  5'b10000, 2'd3, 32'h80FF_0000, 32'hFFFF_FF80);
        load_case("ld_bu3", 5'b01000, 2'd3, 32'h80FF_0000, 32'h0000_0080);
        load_case("ld_hu2", 5'b00010, 2'd2, 32'h80FF_0000, 32'h0000_80FF);
        load_case("ld_b1",  5'b10000, 2'd1, 32'h0000_7F00, 32'h0000_007F);
        load_case("ld_w",   5'b00001, 2'd0, 32'hA5A5_0F0F, 32'hA5A5_0F0F);

        tick; send(32'h1c00_0200, 32'h0, 5'd8, 5'b00100, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        tick; idle; data_ok = 1'b1; rdata = 32'h1234_8001; #1;
        check("min_lat_valid", ms_to_ws_valid, 1);
        check("min_lat_ld_h", ms_final_result, 32'hFFFF_8001);
        tick; data_ok = 1'b0;

        tick; send(32'h1c00_0300, 32'h0, 5'd9, 5'b00001, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        tick; idle; wb_flush = 1'b1; #1;
        check("fl1_stall", ms_fwd_stall, 1);
        tick; wb_flush = 1'b0;
        send(32'h1c00_0304, 32'h0, 5'd9, 5'b00001, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0); #1;
        check("fl1_allowin", es_if.ms_allowin, 1);
        tick; idle; data_ok = 1'b1; rdata = 32'hDEAD_BEEF; #1;
        check("fl1_discard", ms_to_ws_valid, 0);
        tick; rdata = 32'hCAFE_F00D; #1;
        check("fl1_valid", ms_to_ws_valid, 1);
        check("fl1_result", ms_final_result, 32'hCAFE_F00D);
        tick; data_ok = 1'b0;

        tick; send(32'h1c00_0400, 32'h0, 5'd10, 5'b00001, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        tick; idle; ws_allowin = 1'b0; data_ok = 1'b1; rdata = 32'h1122_3344; #1;
        check("stall_valid0", ms_to_ws_valid, 1);
        check("stall_allowin0", es_if.ms_allowin, 0);
        check("stall_result0", ms_final_result, 32'h1122_3344);
        check("stall_fwd_stall0", ms_fwd_stall, STALL_ON_OK);
        for (int i = 1; i < 3; i++) begin
            tick; data_ok = 1'b0; rdata = 32'hFFFF_FFFF; #1;
            check($sformatf("stall_allowin%0d", i), es_if.ms_allowin, 0);
            check($sformatf("stall_valid%0d", i), ms_to_ws_valid, 1);
            check($sformatf("stall_result%0d", i), ms_final_result, 32'h1122_3344);
            check($sformatf("stall_fwd_data%0d", i), ms_fwd_data, 32'h1122_3344);
            check($sformatf("stall_fwd_stall%0d", i), ms_fwd_stall, 0);
        end
        tick; ws_allowin = 1'b1; #1;
        check("stall_release_allowin", es_if.ms_allowin, 1);
        check("stall_release_valid", ms_to_ws_valid, 1);
        tick; #1;
        check("stall_drained", ms_to_ws_valid, 0);

        tick; send(32'h1c00_0500, 32'h0, 5'd11, 5'b00001, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        tick; send(32'h1c00_0504, 32'h0, 5'd12, 5'b00001, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        wb_flush = 1'b1; #1;
        check("fl2_allowin_wait", es_if.ms_allowin, 0);
        tick; idle; wb_flush = 1'b0; #1;
        check("fl2_empty", ms_to_ws_valid, 0);
        tick; send(32'h1c00_0508, 32'h0, 5'd13, 5'b00001, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        data_ok = 1'b1; rdata = 32'h0000_0001; #1;
        check("fl2_accept", es_if.ms_allowin, 1);
        tick; idle; rdata = 32'h0000_0002; #1;
        check("fl2_discard2", ms_to_ws_valid, 0);
        check("fl2_stall", ms_fwd_stall, 1);
        tick; rdata = 32'h55AA_55AA; #1;
        check("fl2_valid", ms_to_ws_valid, 1);
        check("fl2_result", ms_final_result, 32'h55AA_55AA);
        check("fl2_pc", ms_pc, 32'h1c00_0508);
        tick; data_ok = 1'b0;

        tick; send(32'h1c00_0600, 32'h1, 5'd9, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        tick; idle; #1;
        check("ex_valid", ms_to_ws_valid, 1);
        check("ex_gr_we", ms_gr_we, 0);
        check("ex_flag", ms_ex, 1);
        check("ex_kill", ms_ex_kill, 1);
        check("ex_fwd_valid", ms_fwd_valid, 0);
        tick; #1;
        check("ex_kill_clear", ms_ex_kill, 0);

        tick; send(32'h1c00_0700, 32'h0000_ABCD, 5'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick; idle; #1;
        check("st_wait", ms_to_ws_valid, 0);
        check("st_no_stall", ms_fwd_stall, 0);
        tick; data_ok = 1'b1; rdata = 32'h7777_7777; #1;
        check("st_valid", ms_to_ws_valid, 1);
        check("st_result", ms_final_result, 32'h0000_ABCD);
        tick; data_ok = 1'b0;

        tick; send(32'h1c00_0800, 32'h0, 5'd14, 5'b00001, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        tick; idle; wb_flush = 1'b1;
        tick; wb_flush = 1'b0;
        send(32'h1c00_0804, 32'h0, 5'd14, 5'b00001, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        tick; idle; #1;
        check("rst_mid_wait", es_if.ms_allowin, 0);
        #2 resetn = 1'b0;
        #1;
        check("rst_mid_allowin", es_if.ms_allowin, 1);
        check("rst_mid_stall", ms_fwd_stall, 0);
        #1 resetn = 1'b1;
        tick; send(32'h1c00_0900, 32'h0, 5'd15, 5'b00001, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        tick; idle; data_ok = 1'b1; rdata = 32'h600D_F00D; #1;
        check("rst_after_valid", ms_to_ws_valid, 1);
        check("rst_after_result", ms_final_result, 32'h600D_F00D);
        tick; data_ok = 1'b0;

        tick;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
